// File: rtl/fpc_dec_top.sv
// -----------------------------------------------------------------------------
// fpc_dec_top
//
// Receive-side forbidden-pattern-free (FPC) decoder. One 40-bit coded word
// per transfer is split into eight 5-bit lanes. Each lane decodes back to a
// 4-bit nibble. Lanes holding a pattern outside the 16-entry codebook decode
// to 0 and raise their lane_err bit. A saturating 16-bit counter tallies
// illegal lanes for link monitoring.
//
// Two-stage pipeline with valid/ready on both sides:
//   stage 1 : raw coded word register
//   stage 2 : decoded word / lane error register (drives the outputs)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid   data_in holds a coded word
//   in_ready   stage 1 can accept this cycle
//   data_in    coded word, lane k = data_in[5k+4:5k]
//   out_valid  data_out / lane_err hold a decoded word
//   out_ready  consumer accepts this cycle
//   data_out   decoded word, nibble k = data_out[4k+3:4k]
//   lane_err   bit k set when lane k of the word was illegal
//   err_cnt    saturating count of illegal lanes
//   err_clr    synchronous clear of err_cnt (wins over an increment)
// -----------------------------------------------------------------------------
module fpc_dec_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [39:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic [7:0]  lane_err,
    output logic [15:0] err_cnt,
    input  logic        err_clr
);

    localparam int LANES  = 8;
    localparam int CW_W   = 5;
    localparam int NIB_W  = 4;
    localparam int DATA_W = LANES * CW_W;
    localparam int OUT_W  = LANES * NIB_W;
    localparam int CNT_W  = 16;

    // Returns {illegal, nibble}. The nibble is the codeword's rank among the
    // legal patterns in ascending binary order.
    function automatic logic [4:0] decode_lane(input logic [CW_W-1:0] cw);
        logic [4:0] r;
        case (cw)
            5'b00000: r = 5'h00;
            5'b00001: r = 5'h01;
            5'b00011: r = 5'h02;
            5'b00110: r = 5'h03;
            5'b00111: r = 5'h04;
            5'b01100: r = 5'h05;
            5'b01110: r = 5'h06;
            5'b01111: r = 5'h07;
            5'b10000: r = 5'h08;
            5'b10001: r = 5'h09;
            5'b10011: r = 5'h0A;
            5'b11000: r = 5'h0B;
            5'b11001: r = 5'h0C;
            5'b11100: r = 5'h0D;
            5'b11110: r = 5'h0E;
            5'b11111: r = 5'h0F;
            default:  r = 5'h10;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] popcount8(input logic [LANES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Saturates at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [3:0]       n);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-3){1'b0}}, n};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic [OUT_W-1:0]  data_p2;
    logic [LANES-1:0]  err_p2;
    logic              vld_p2;
    logic [CNT_W-1:0]  cnt_p2;

    logic [OUT_W-1:0]  dec_data;
    logic [LANES-1:0]  dec_err;
    logic [4:0]        lane_dec;
    logic              s1_load;
    logic              s2_load;

    // Stage 2 frees up either when empty or when its word leaves this cycle,
    // so stage 1 can hand over and refill on the same edge.
    assign s2_load  = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || s2_load;
    assign s1_load  = in_valid && in_ready;

    // ---- stage 1: raw coded word ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            if (s1_load) begin
                data_p1 <= data_in;
                vld_p1  <= 1'b1;
            end else if (s2_load) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    // ---- stage 1 -> stage 2: combinational lane decode ----
    always_comb begin
        dec_data = '0;
        dec_err  = '0;
        lane_dec = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_dec                   = decode_lane(data_p1[CW_W*k +: CW_W]);
            dec_data[NIB_W*k +: NIB_W] = lane_dec[3:0];
            dec_err[k]                 = lane_dec[4];
        end
    end

    // ---- stage 2: decoded word, lane errors, error counter ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            err_p2  <= '0;
        end else begin
            if (s2_load) begin
                data_p2 <= dec_data;
                err_p2  <= dec_err;
                vld_p2  <= 1'b1;
            end else if (out_ready) begin
                vld_p2  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p2 <= '0;
        end else begin
            if (err_clr) begin
                cnt_p2 <= '0;
            end else if (s2_load) begin
                cnt_p2 <= sat_add(cnt_p2, popcount8(dec_err));
            end
        end
    end

    assign out_valid = vld_p2;
    assign data_out  = data_p2;
    assign lane_err  = err_p2;
    assign err_cnt   = cnt_p2;

endmodule

// File: tb/tb_fpc_dec_top.sv
`timescale 1ns/1ps
module tb_fpc_dec_top;

    typedef struct {
        logic [39:0] din;
        logic [31:0] dout;
        logic [7:0]  err;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic [7:0]  err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [7:0]  lane_err;
    logic [15:0] err_cnt;
    logic        err_clr;

    fpc_dec_top dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .lane_err  (lane_err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    exp_t        sb[$];
    logic [15:0] exp_cnt;
    bit          stall_prev;
    logic [31:0] hold_data;
    logic [7:0]  hold_err;
    bit          last_acc;
    logic [31:0] drv_dout;
    logic [7:0]  drv_err;

    localparam logic [4:0] CB [16] = '{5'b00000, 5'b00001, 5'b00011, 5'b00110,
                                       5'b00111, 5'b01100, 5'b01110, 5'b01111,
                                       5'b10000, 5'b10001, 5'b10011, 5'b11000,
                                       5'b11001, 5'b11100, 5'b11110, 5'b11111};

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Independent reference: legality by 3-bit window scan, nibble by rank.
    function automatic bit is_legal(input logic [4:0] cw);
        bit ok;
        logic [2:0] w;
        ok = 1'b1;
        for (int j = 0; j < 3; j++) begin
            w = cw[j +: 3];
            if (w == 3'b010 || w == 3'b101) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] rank(input logic [4:0] cw);
        int c;
        logic [4:0] pv;
        c = 0;
        for (int p = 0; p < 32; p++) begin
            pv = 5'(p);
            if (pv < cw && is_legal(pv)) c++;
        end
        return 4'(c);
    endfunction

    task automatic model_word(input logic [39:0] d, output logic [31:0] o, output logic [7:0] e);
        logic [4:0] cw;
        o = '0;
        e = '0;
        for (int k = 0; k < 8; k++) begin
            cw = d[5*k +: 5];
            if (is_legal(cw)) o[4*k +: 4] = rank(cw);
            else              e[k] = 1'b1;
        end
    endtask

    task automatic set_word(input logic [39:0] d, input logic [31:0] ed, input logic [7:0] ee);
        in_valid = 1'b1;
        data_in  = d;
        drv_dout = ed;
        drv_err  = ee;
    endtask

    task automatic set_model(input logic [39:0] d);
        logic [31:0] o;
        logic [7:0]  e;
        model_word(d, o, e);
        set_word(d, o, e);
    endtask

    // One clock: sample just after the falling edge, score outputs, record
    // accepted stimulus, then advance to the next falling edge.
    task automatic cycle();
        exp_t e;
        int   s;
        #1;
        last_acc = in_valid && in_ready;
        if (stall_prev) begin
            chk("stall_hold_data", 40'(data_out), 40'(hold_data));
            chk("stall_hold_err", 40'(lane_err), 40'(hold_err));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected no word", data_out);
            end else begin
                e = sb.pop_front();
                chk("data_out", 40'(data_out), 40'(e.dout));
                chk("lane_err", 40'(lane_err), 40'(e.err));
            end
        end
        if (last_acc) begin
            e.dout = drv_dout;
            e.err  = drv_err;
            sb.push_back(e);
            s = int'(exp_cnt) + $countones(drv_err);
            exp_cnt = (s > 65535) ? 16'hFFFF : 16'(s);
        end
        stall_prev = out_valid && !out_ready;
        hold_data  = data_out;
        hold_err   = lane_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_one();
        last_acc = 1'b0;
        for (int t = 0; t < 50 && !last_acc; t++) cycle();
        if (!last_acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready stuck, expected acceptance");
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && sb.size() > 0; t++) cycle();
        chk("drain_empty", 40'(sb.size()), 40'(0));
        cycle();
        cycle();
    endtask

    vec_t        tbl[18];
    logic [63:0] r;
    int          j;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_cnt    = '0;
        stall_prev = 1'b0;
        hold_data  = '0;
        hold_err   = '0;
        drv_dout   = '0;
        drv_err    = '0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        data_in    = '0;
        out_ready  = 1'b1;
        err_clr    = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 40'(out_valid), 40'(0));
        chk("rst_data_out", 40'(data_out), 40'(0));
        chk("rst_lane_err", 40'(lane_err), 40'(0));
        chk("rst_err_cnt", 40'(err_cnt), 40'(0));
        @(negedge clk);
        rst = 1'b1;
        chk("rst_in_ready", 40'(in_ready), 40'(1));

        // Latency of first word
        set_word({5'b01111, 5'b01110, 5'b01100, 5'b00111, 5'b00110, 5'b00011, 5'b00001, 5'b00000},
                 32'h76543210, 8'h00);
        cycle();
        chk("lat_accept", 40'(last_acc), 40'(1));
        in_valid = 1'b0;
        chk("lat_edge_n", 40'(out_valid), 40'(0));
        cycle();
        chk("lat_edge_n1", 40'(out_valid), 40'(1));
        drain();
        chk("legal_err_cnt", 40'(err_cnt), 40'(0));

        // Table: legal word, codebook sweep, illegal lanes
        tbl[0] = '{din: {5'b01111, 5'b01110, 5'b01100, 5'b00111, 5'b00110, 5'b00011, 5'b00001, 5'b00000},
                   dout: 32'h76543210, err: 8'h00};
        for (int i = 0; i < 16; i++) begin
            tbl[i+1].din  = {8{CB[i]}};
            tbl[i+1].dout = {8{4'(i)}};
            tbl[i+1].err  = 8'h00;
        end
        tbl[17] = '{din: {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01010, 5'b00000, 5'b00000, 5'b10101},
                    dout: 32'h00000000, err: 8'h09};
        for (int i = 0; i < 18; i++) begin
            set_word(tbl[i].din, tbl[i].dout, tbl[i].err);
            send_one();
        end
        drain();
        chk("illegal_err_cnt", 40'(err_cnt), 40'(2));

        // Random words with random valid/ready
        for (int i = 0; i < 60; i++) begin
            r = {$urandom(), $urandom()};
            set_model(r[39:0]);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();
        chk("random_err_cnt", 40'(err_cnt), 40'(exp_cnt));

        // Backpressure: 5 distinct words, out_ready low for 4 cycles
        j = 0;
        for (int c = 0; c < 40 && j < 5; c++) begin
            set_model({8{CB[j+3]}});
            out_ready = (c >= 4);
            cycle();
            if (last_acc) begin
                j++;
                if (j == 2) chk("bp_in_ready_low", 40'(in_ready), 40'(0));
            end
        end
        chk("bp_all_accepted", 40'(j), 40'(5));
        drain();

        // Clear wins over a simultaneous erroring stage-2 load
        out_ready = 1'b1;
        set_word(tbl[17].din, 32'h0, 8'h09);
        send_one();
        in_valid = 1'b0;
        err_clr  = 1'b1;
        cycle();
        err_clr  = 1'b0;
        chk("clr_priority", 40'(err_cnt), 40'(0));
        exp_cnt = '0;
        drain();
        chk("clr_after_drain", 40'(err_cnt), 40'(0));

        // Saturation: preload to 0xFFFE, then 8 more errors
        for (int i = 0; i < 8191; i++) begin
            set_word({8{5'b01010}}, 32'h0, 8'hFF);
            send_one();
        end
        for (int i = 0; i < 6; i++) begin
            set_word({35'd0, 5'b01010}, 32'h0, 8'h01);
            send_one();
        end
        drain();
        chk("sat_preload", 40'(err_cnt), 40'(16'hFFFE));
        set_word({8{5'b10101}}, 32'h0, 8'hFF);
        send_one();
        drain();
        chk("sat_max", 40'(err_cnt), 40'(16'hFFFF));
        set_word({35'd0, 5'b10101}, 32'h0, 8'h01);
        send_one();
        drain();
        chk("sat_no_wrap", 40'(err_cnt), 40'(16'hFFFF));

        // Async reset with both stages full
        out_ready = 1'b0;
        set_word(tbl[17].din, 32'h0, 8'h09);
        send_one();
        set_word({8{5'b01010}}, 32'h0, 8'hFF);
        send_one();
        in_valid = 1'b0;
        chk("full_in_ready", 40'(in_ready), 40'(0));
        chk("full_out_valid", 40'(out_valid), 40'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 40'(out_valid), 40'(0));
        chk("arst_lane_err", 40'(lane_err), 40'(0));
        chk("arst_data_out", 40'(data_out), 40'(0));
        chk("arst_err_cnt", 40'(err_cnt), 40'(0));
        chk("arst_in_ready", 40'(in_ready), 40'(1));
        sb.delete();
        exp_cnt    = '0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        chk("post_rst_in_ready", 40'(in_ready), 40'(1));
        set_word({8{CB[10]}}, 32'hAAAAAAAA, 8'h00);
        send_one();
        drain();
        chk("post_rst_err_cnt", 40'(err_cnt), 40'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
